// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory bus between the instruction and
// data caches. Data-cache stores go through a one-entry write buffer that
// always drains before any read is started. Line reads are granted
// round-robin. One bus transaction is in flight at a time, and every
// transaction is followed by a one-cycle recovery gap.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int LINE_W = 1024,
    parameter int OFFS_W = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rd,
    output logic              i_dv,
    output logic [LINE_W-1:0] i_data,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_rd,
    output logic              d_dv,
    output logic [LINE_W-1:0] d_data,
    input  logic              d_wr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              wb_full,
    output logic              wb_ovf,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rd,
    output logic              m_wr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_dv
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_I    = 3'd1,
        S_RD_D    = 3'd2,
        S_WR      = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    // last_grant encoding: 1 means the data cache was served last
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Clears the in-line offset so the bus always sees line-aligned addresses
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFS_W) - ADDR_W'(1));

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_rd_q, m_rd_d;
    logic                m_wr_q, m_wr_d;
    logic [LINE_W-1:0]   m_wdata_q, m_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [LINE_W-1:0]   wb_data_q, wb_data_d;
    logic                wb_ovf_q, wb_ovf_d;
    logic                abort_q, abort_d;
    logic                last_grant_q, last_grant_d;
    logic                drain;

    // State and bus-side registers, all cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= S_IDLE;
            m_addr_q     <= '0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            m_wdata_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_ovf_q     <= 1'b0;
            abort_q      <= 1'b0;
            last_grant_q <= GNT_D;
        end else begin
            state_q      <= state_d;
            m_addr_q     <= m_addr_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            m_wdata_q    <= m_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            wb_ovf_q     <= wb_ovf_d;
            abort_q      <= abort_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Write-buffer update plus next-state and bus-request decode
    always_comb begin
        state_d      = state_q;
        m_addr_d     = m_addr_q;
        m_rd_d       = m_rd_q;
        m_wr_d       = m_wr_q;
        m_wdata_d    = m_wdata_q;
        wb_valid_d   = wb_valid_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        wb_ovf_d     = wb_ovf_q;
        abort_d      = abort_q;
        last_grant_d = last_grant_q;

        // The buffered entry is retired only by the completion of a write
        drain = (state_q == S_WR) && m_dv;

        // A new store always wins. It counts as an overflow only if it
        // displaces an entry that is not retiring in this same cycle.
        if (d_wr) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = d_addr & LINE_MASK;
            wb_data_d  = d_wdata;
            if (wb_valid_q && !drain) begin
                wb_ovf_d = 1'b1;
            end
        end else if (drain) begin
            wb_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Stores arriving this cycle also take precedence over reads,
                // which keeps a same-cycle store/load to one line coherent.
                if (wb_valid_q || d_wr) begin
                    state_d   = S_WR;
                    m_wr_d    = 1'b1;
                    m_addr_d  = d_wr ? (d_addr & LINE_MASK) : wb_addr_q;
                    m_wdata_d = d_wr ? d_wdata : wb_data_q;
                end else if (i_rd && (!d_rd || last_grant_q == GNT_D)) begin
                    state_d      = S_RD_I;
                    m_rd_d       = 1'b1;
                    m_addr_d     = i_addr & LINE_MASK;
                    last_grant_d = GNT_I;
                end else if (d_rd) begin
                    state_d      = S_RD_D;
                    m_rd_d       = 1'b1;
                    m_addr_d     = d_addr & LINE_MASK;
                    last_grant_d = GNT_D;
                end
            end
            S_RD_I: begin
                if (m_dv) begin
                    state_d = S_RECOVER;
                    m_rd_d  = 1'b0;
                    abort_d = 1'b0;
                end else if (!i_rd) begin
                    abort_d = 1'b1;
                end
            end
            S_RD_D: begin
                if (m_dv) begin
                    state_d = S_RECOVER;
                    m_rd_d  = 1'b0;
                    abort_d = 1'b0;
                end else if (!d_rd) begin
                    abort_d = 1'b1;
                end
            end
            S_WR: begin
                if (m_dv) begin
                    state_d = S_RECOVER;
                    m_wr_d  = 1'b0;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                m_rd_d  = 1'b0;
                m_wr_d  = 1'b0;
            end
        endcase
    end

    // Completion is steered to the owner only; an abandoned read is swallowed
    assign i_dv    = m_dv && (state_q == S_RD_I) && !abort_q;
    assign d_dv    = m_dv && (state_q == S_RD_D) && !abort_q;
    assign i_data  = m_rdata;
    assign d_data  = m_rdata;

    assign wb_full = wb_valid_q;
    assign wb_ovf  = wb_ovf_q;
    assign m_addr  = m_addr_q;
    assign m_rd    = m_rd_q;
    assign m_wr    = m_wr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cache traffic against a simple memory
// responder. Expected bus events are queued by the stimulus, and a monitor
// pops them as the DUT presents requests and fill strobes.
module tb_mem_arbiter;

    localparam int ADDR_W = 64;
    localparam int LINE_W = 1024;
    localparam int OFFS_W = 7;

    localparam logic [1:0] K_MRD = 2'd0;
    localparam logic [1:0] K_MWR = 2'd1;
    localparam logic [1:0] K_IDV = 2'd2;
    localparam logic [1:0] K_DDV = 2'd3;

    typedef struct {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              clr;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic              i_rd, d_rd, d_wr;
    logic [LINE_W-1:0] d_wdata;
    logic              i_dv, d_dv, wb_full, wb_ovf, m_rd, m_wr;
    logic [LINE_W-1:0] i_data, d_data, m_wdata, m_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic              resp_dv, stray_dv, m_dv;
    logic              resp_en;
    int                mem_lat;

    int  total = 0;
    int  bad   = 0;
    ev_t exp_q[$];

    assign m_dv = resp_dv | stray_dv;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFFS_W(OFFS_W)) dut (
        .clk(clk), .clr(clr),
        .i_addr(i_addr), .i_rd(i_rd), .i_dv(i_dv), .i_data(i_data),
        .d_addr(d_addr), .d_rd(d_rd), .d_dv(d_dv), .d_data(d_data),
        .d_wr(d_wr), .d_wdata(d_wdata), .wb_full(wb_full), .wb_ovf(wb_ovf),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_dv(m_dv)
    );

    // Memory read data is a fixed function of the line address
    function automatic logic [LINE_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {16{a ^ 64'hA5A5_0000_0000_0000}};
    endfunction

    function automatic string kname(input logic [1:0] k);
        case (k)
            K_MRD:   return "MRD";
            K_MWR:   return "MWR";
            K_IDV:   return "IDV";
            default: return "DDV";
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [1:0] k, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s: got addr %0h data[63:0] %0h, want no event", kname(k), a, d[63:0]);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                bad++;
                $display("FAIL event: got %s addr %0h data[63:0] %0h want %s addr %0h data[63:0] %0h",
                         kname(k), a, d[63:0], kname(e.kind), e.addr, e.data[63:0]);
            end else begin
                $display("ok   event %s addr %0h data[63:0] %0h", kname(k), a, d[63:0]);
            end
        end
    endtask

    // Monitor: samples just before each rising edge
    initial begin
        logic              prev_rd;
        logic              prev_wr;
        logic [ADDR_W-1:0] prev_addr;
        prev_rd   = 1'b0;
        prev_wr   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            if ((m_rd && prev_rd) || (m_wr && prev_wr)) begin
                if (m_addr !== prev_addr) begin
                    check("m_addr stable", m_addr, prev_addr);
                end
            end
            if (m_rd && !prev_rd) observe(K_MRD, m_addr, '0);
            if (m_wr && !prev_wr) observe(K_MWR, m_addr, m_wdata);
            if (i_dv) observe(K_IDV, m_addr, i_data);
            if (d_dv) observe(K_DDV, m_addr, d_data);
            prev_rd   = m_rd;
            prev_wr   = m_wr;
            prev_addr = m_addr;
        end
    end

    // Memory responder: completes a request after mem_lat cycles unless stalled
    initial begin
        int cnt;
        cnt     = 0;
        resp_dv = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (resp_en && (m_rd || m_wr) && !resp_dv) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    resp_dv = 1'b1;
                    m_rdata = pat(m_addr);
                    cnt     = 0;
                end
            end else begin
                resp_dv = 1'b0;
                if (!(m_rd || m_wr)) cnt = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit cond(input int sel);
        case (sel)
            0:       return m_rd;
            1:       return m_wr;
            2:       return i_dv || d_dv;
            3:       return m_wr && m_dv;
            default: return !m_rd && !m_wr;
        endcase
    endfunction

    // Waits (bounded) until a condition is sampled true; leaves time at the sample point
    task automatic wait_sig(input string name, input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            #4;
            if (cond(sel)) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic wait_dvs(input string name, input int n, input int budget);
        int got;
        got = 0;
        for (int k = 0; k < budget && got < n; k++) begin
            @(negedge clk);
            #4;
            if (i_dv || d_dv) got++;
        end
        check(name, 64'(got), 64'(n));
    endtask

    task automatic pulse_reset();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int n;
        bit got;
        logic [LINE_W-1:0] la, lb1, lb2, lc1, lc2, ld1;
        la  = {16{64'hDEAD_BEEF_0000_0001}};
        lb1 = {16{64'h1111_2222_3333_0001}};
        lb2 = {16{64'h4444_5555_6666_0002}};
        lc1 = {16{64'hC0C0_0000_0000_00C1}};
        lc2 = {16{64'hC0C0_0000_0000_00C2}};
        ld1 = {16{64'hD0D0_0000_0000_00D1}};

        clr = 1'b1; i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        resp_en = 1'b1; mem_lat = 3; stray_dv = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst m_rd", 64'(m_rd), 64'd0);
        check("rst m_wr", 64'(m_wr), 64'd0);
        check("rst m_addr", m_addr, 64'd0);
        check("rst m_wdata", 64'(|m_wdata), 64'd0);
        check("rst wb_full", 64'(wb_full), 64'd0);
        check("rst wb_ovf", 64'(wb_ovf), 64'd0);
        check("rst i_dv", 64'(i_dv), 64'd0);
        check("rst d_dv", 64'(d_dv), 64'd0);
        clr = 1'b0;

        // Single icache read, latency 3
        i_addr = 64'h1234; i_rd = 1'b1;
        push(K_MRD, 64'h1200, '0);
        push(K_IDV, 64'h1200, pat(64'h1200));
        n = 0; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            #4;
            if (m_rd) n++;
            if (i_dv) got = 1'b1;
        end
        check("single i_dv seen", 64'(got), 64'd1);
        check("single m_rd cycles", 64'(n), 64'd3);
        @(negedge clk);
        check("single recover m_rd", 64'(m_rd), 64'd0);
        i_rd = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: I wins the first tie after reset, then alternate
        pulse_reset();
        mem_lat = 2;
        i_addr = 64'h1000; d_addr = 64'h2000; i_rd = 1'b1; d_rd = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(K_MRD, 64'h1000, '0);
            push(K_IDV, 64'h1000, pat(64'h1000));
            push(K_MRD, 64'h2000, '0);
            push(K_DDV, 64'h2000, pat(64'h2000));
        end
        wait_dvs("contention dv count", 4, 60);
        @(negedge clk);
        i_rd = 1'b0; d_rd = 1'b0;
        repeat (3) @(negedge clk);

        // Store and load to the same line in one cycle: write drains first
        d_addr = 64'h80; d_wdata = la; d_wr = 1'b1; d_rd = 1'b1;
        push(K_MWR, 64'h80, la);
        push(K_MRD, 64'h80, '0);
        push(K_DDV, 64'h80, pat(64'h80));
        @(negedge clk);
        d_wr = 1'b0;
        check("store wb_full set", 64'(wb_full), 64'd1);
        wait_sig("store write done", 3, 20);
        @(negedge clk);
        check("store wb_full clear", 64'(wb_full), 64'd0);
        wait_sig("store read dv", 2, 20);
        @(negedge clk);
        d_rd = 1'b0;
        repeat (2) @(negedge clk);

        // Overflow: two stores while a read is stalled; only the second is written
        resp_en = 1'b0;
        i_addr = 64'h3000; i_rd = 1'b1;
        push(K_MRD, 64'h3000, '0);
        wait_sig("ovf read started", 0, 10);
        @(negedge clk);
        d_addr = 64'h100; d_wdata = lb1; d_wr = 1'b1;
        @(negedge clk);
        d_wr = 1'b0;
        @(negedge clk);
        d_addr = 64'h200; d_wdata = lb2; d_wr = 1'b1;
        @(negedge clk);
        d_wr = 1'b0;
        check("ovf wb_ovf set", 64'(wb_ovf), 64'd1);
        check("ovf wb_full", 64'(wb_full), 64'd1);
        push(K_IDV, 64'h3000, pat(64'h3000));
        push(K_MWR, 64'h200, lb2);
        resp_en = 1'b1;
        wait_sig("ovf read dv", 2, 20);
        @(negedge clk);
        i_rd = 1'b0;
        wait_sig("ovf write done", 3, 20);
        @(negedge clk);
        check("ovf wb_full clear", 64'(wb_full), 64'd0);
        check("ovf sticky", 64'(wb_ovf), 64'd1);
        repeat (2) @(negedge clk);

        // Store landing in the same cycle as the write completion: no overflow
        pulse_reset();
        mem_lat = 3;
        d_addr = 64'h300; d_wdata = lc1; d_wr = 1'b1;
        push(K_MWR, 64'h300, lc1);
        @(negedge clk);
        d_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d_addr = 64'h400; d_wdata = lc2; d_wr = 1'b1;
        push(K_MWR, 64'h400, lc2);
        #4;
        check("coincide m_wr", 64'(m_wr), 64'd1);
        @(negedge clk);
        d_wr = 1'b0;
        check("coincide wb_ovf", 64'(wb_ovf), 64'd0);
        check("coincide wb_full", 64'(wb_full), 64'd1);
        wait_sig("coincide second write", 3, 20);
        @(negedge clk);
        check("coincide wb_full clear", 64'(wb_full), 64'd0);
        repeat (2) @(negedge clk);

        // Abort: icache drops its request mid-read; fill is swallowed
        mem_lat = 3;
        i_addr = 64'h5000; i_rd = 1'b1;
        push(K_MRD, 64'h5000, '0);
        wait_sig("abort read started", 0, 10);
        @(negedge clk);
        i_rd = 1'b0;
        wait_sig("abort bus idle", 4, 20);
        repeat (2) @(negedge clk);
        i_addr = 64'h5080; i_rd = 1'b1;
        push(K_MRD, 64'h5080, '0);
        push(K_IDV, 64'h5080, pat(64'h5080));
        wait_sig("after abort dv", 2, 20);
        @(negedge clk);
        i_rd = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while a dcache read is stalled with a store buffered
        resp_en = 1'b0;
        d_addr = 64'h7000; d_rd = 1'b1;
        push(K_MRD, 64'h7000, '0);
        wait_sig("midrst read started", 0, 10);
        @(negedge clk);
        d_wdata = ld1; d_wr = 1'b1;
        @(negedge clk);
        d_wr = 1'b0;
        check("midrst wb_full before", 64'(wb_full), 64'd1);
        clr = 1'b1; d_rd = 1'b0;
        @(negedge clk);
        check("midrst m_rd", 64'(m_rd), 64'd0);
        check("midrst m_wr", 64'(m_wr), 64'd0);
        check("midrst m_addr", m_addr, 64'd0);
        check("midrst wb_full", 64'(wb_full), 64'd0);
        clr = 1'b0;
        stray_dv = 1'b1;
        @(negedge clk);
        stray_dv = 1'b0;
        repeat (2) @(negedge clk);
        check("stray m_rd", 64'(m_rd), 64'd0);
        check("stray m_wr", 64'(m_wr), 64'd0);
        resp_en = 1'b1; mem_lat = 2;
        i_addr = 64'h8000; d_addr = 64'h9000; i_rd = 1'b1; d_rd = 1'b1;
        push(K_MRD, 64'h8000, '0);
        push(K_IDV, 64'h8000, pat(64'h8000));
        push(K_MRD, 64'h9000, '0);
        push(K_DDV, 64'h9000, pat(64'h9000));
        wait_dvs("post reset tie dv count", 2, 40);
        @(negedge clk);
        i_rd = 1'b0; d_rd = 1'b0;
        repeat (4) @(negedge clk);

        check("expected events drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external line-wide memory bus between the hart's instruction cache and data cache. It holds a one-entry write-through buffer for data-cache stores and arbitrates line reads round-robin between the two caches. It sequences one memory transaction at a time and routes the completion strobe and fill data only to the granted requester. It sits between the caches' `b_*` bus ports and the external memory interface.

## Interface
- `ADDR_W`, 64: address width.
- `LINE_W`, 1024: cache line width in bits.
- `OFFS_W`, 7: line offset bits; forced to zero on `m_addr`.
- `clk` in 1: clock; all state changes on rising edge.
- `clr` in 1: reset; one clock; reset is synchronous and active-high.
- `i_addr` in ADDR_W: icache line address.
- `i_rd` in 1: icache read request (level).
- `i_dv` out 1: icache fill valid.
- `i_data` out LINE_W: icache fill data.
- `d_addr` in ADDR_W: dcache line address.
- `d_rd` in 1: dcache read request (level).
- `d_dv` out 1: dcache fill valid.
- `d_data` out LINE_W: dcache fill data.
- `d_wr` in 1: dcache write-through strobe (may be 1 cycle).
- `d_wdata` in LINE_W: dcache line to write.
- `wb_full` out 1: write buffer occupied.
- `wb_ovf` out 1: sticky, write accepted while buffer full.
- `m_addr` out ADDR_W: memory line address.
- `m_rd` out 1: memory read request.
- `m_wr` out 1: memory write request.
- `m_wdata` out LINE_W: memory write data.
- `m_rdata` in LINE_W: memory read data.
- `m_dv` in 1: memory completion, 1-cycle pulse.

## Operation
- **States:** IDLE, RD_I, RD_D, WR, RECOVER. The state and all `m_*` outputs are registered.
- **Write buffer**
  - `d_wr` high captures `{d_addr[ADDR_W-1:OFFS_W], d_wdata}` and sets `wb_valid`.
  - `wb_full` equals `wb_valid`.
  - `d_wr` while `wb_valid` and the buffer is not draining this cycle: the new entry overwrites the old one and `wb_ovf` sets.
  - `d_wr` in the same cycle as the WR completion (`m_dv`) is accepted with no overflow. `wb_valid` stays 1 with the new entry.
- **IDLE priority**
  1. `wb_valid` goes to WR. Stores always drain before any read, so a dcache read-after-write to the same line is coherent.
  2. Otherwise, if both `i_rd` and `d_rd` are asserted, the requester other than `last_grant` wins (round-robin).
  3. Otherwise, the single requester wins.
  4. Otherwise, stay in IDLE.
  - `last_grant` updates when a read is granted. Its reset value is D, so I wins the first tie.
- **RD_I / RD_D / WR**
  - `m_addr` is latched from the requester or buffer on entry, with the low OFFS_W bits zero.
  - `m_rd` or `m_wr` is held high and `m_addr`/`m_wdata` stay stable until `m_dv`.
- **Completion**
  - `i_dv = m_dv & (state==RD_I) & ~abort`, combinational. `d_dv` is the same with RD_D.
  - `i_data` and `d_data` are driven directly from `m_rdata`.
  - On `m_dv`: the state goes to RECOVER, and WR clears `wb_valid` (unless refilled the same cycle).
- **RECOVER:** one cycle with `m_rd`=`m_wr`=0, then IDLE. This guarantees the request drops between transactions.
- **Abort:** if the granted requester's `rd` drops before `m_dv`, set `abort`. The bus transaction still completes, its `dv` is suppressed, and `abort` clears on completion.
- `m_dv` outside RD_I, RD_D and WR is ignored.
- **Reset values:** state IDLE; `m_rd`=`m_wr`=0; `m_addr`=0; `m_wdata`=0; `wb_valid`=`wb_full`=`wb_ovf`=0; `abort`=0; `last_grant`=D; `i_dv`=`d_dv`=0.
- **Reset mid-transaction:** outputs return to reset values on the next edge and the in-flight transaction is dropped. A late `m_dv` arrives in IDLE and is ignored.

## Timing
- A request seen in IDLE at edge t produces `m_rd`/`m_wr` high after edge t+1.
- `m_dv` at cycle k produces `x_dv` in cycle k. `m_rd`/`m_wr` are low from k+1 (RECOVER) and the next grant is possible at k+2.
- Minimum back-to-back transaction period is memory latency + 2 cycles.
- A requester must hold `rd` until its `dv`. Arbiter outputs never depend combinationally on `i_rd`/`d_rd`.

## Test plan
- **Single read:** `i_rd`=1, `i_addr`=0x1234, memory answers 3 cycles after `m_rd`. Expect `m_addr`=0x1200, `m_rd` for 3 cycles, `i_dv` 1 cycle with `i_data`=`m_rdata`, `d_dv`=0, then RECOVER.
- **Contention:** `i_rd` and `d_rd` held continuously, memory latency 2. Expect grants I, D, I, D, and each `dv` goes only to its owner.
- **Store before read:** `d_wr` pulse (addr 0x80, data A) and `d_rd` to 0x80 in the same cycle. Expect WR of A first, then RD_D, and `wb_full` clears on WR `m_dv`.
- **Overflow:** two `d_wr` pulses to different lines while memory stalls. Expect `wb_ovf`=1 (sticky) and only the second line written. A `d_wr` coinciding with the WR `m_dv` leaves `wb_ovf`=0.
- **Abort:** `i_rd` drops mid-transaction. Expect the transaction to complete, `i_dv` to stay 0, and the next grant to be normal.
- **Reset mid-transaction:** `clr` during RD_D. Expect `m_rd`=0 next cycle, `wb_full`=0, a stray `m_dv` ignored, and the first tie afterwards granted to I.
